// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST controller for the 1-port SRAM macro BIST port.
// It walks the six March C- elements at one operation per cycle and checks each
// read one cycle later against the expected background.
// It also keeps sticky pass/fail status and first-failure diagnostics.
module sram_march_bist_ctrl #(
  parameter int                      P_ADDR_WIDTH = 10,
  parameter int                      P_DATA_WIDTH = 32,
  parameter logic [P_DATA_WIDTH-1:0] P_BACKGROUND = '0
) (
  input  logic                    A_BIST_CLK,
  input  logic                    A_BIST_RST,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    FAIL,
  output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [2:0]              FAIL_ELEM,
  output logic [P_DATA_WIDTH-1:0] FAIL_SYN,
  output logic [7:0]              FAIL_CNT,
  output logic                    A_BIST_EN,
  output logic                    A_BIST_MEN,
  output logic                    A_BIST_WEN,
  output logic                    A_BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
  input  logic [P_DATA_WIDTH-1:0] A_DOUT
);

  localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE = P_ADDR_WIDTH'(1);
  localparam logic [2:0]              ELEM_LAST = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                    phase_q, phase_d;
  logic                    start_run;

  logic elem_down;
  logic two_ops;
  logic op_is_read;
  logic read_expects_one;
  logic write_one;
  logic at_terminal;
  logic last_op_of_addr;

  logic                    cmp_valid;
  logic [P_DATA_WIDTH-1:0] cmp_exp;
  logic [P_ADDR_WIDTH-1:0] cmp_addr;
  logic [2:0]              cmp_elem;
  logic [P_DATA_WIDTH-1:0] syndrome;
  logic                    miscompare;

  logic                    fail_q;
  logic [P_ADDR_WIDTH-1:0] fail_addr_q;
  logic [2:0]              fail_elem_q;
  logic [P_DATA_WIDTH-1:0] fail_syn_q;
  logic [7:0]              fail_cnt_q;

  // Decode the current element/phase into the operation being issued this cycle
  always_comb begin
    elem_down        = (elem_q == 3'd3) || (elem_q == 3'd4);
    two_ops          = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    op_is_read       = two_ops ? !phase_q : (elem_q == ELEM_LAST);
    read_expects_one = (elem_q == 3'd2) || (elem_q == 3'd4);
    write_one        = (elem_q == 3'd1) || (elem_q == 3'd3);
    at_terminal      = elem_down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    last_op_of_addr  = !two_ops || phase_q;
  end

  // Next-state logic: sequence operations, addresses and elements
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    addr_d    = addr_q;
    phase_d   = phase_q;
    start_run = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d   = ST_RUN;
          elem_d    = 3'd0;
          addr_d    = '0;
          phase_d   = 1'b0;
          start_run = 1'b1;
        end
      end
      ST_RUN: begin
        if (!last_op_of_addr) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (at_terminal) begin
            if (elem_q == ELEM_LAST) begin
              state_d = ST_DRAIN;
            end else begin
              elem_d = elem_q + 3'd1;
              addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
            end
          end else begin
            addr_d = elem_down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Macro port and status outputs, decoded from the current state
  always_comb begin
    BUSY        = 1'b0;
    DONE        = 1'b0;
    A_BIST_EN   = 1'b0;
    A_BIST_MEN  = 1'b0;
    A_BIST_WEN  = 1'b0;
    A_BIST_REN  = 1'b0;
    A_BIST_ADDR = '0;
    A_BIST_DIN  = '0;
    A_BIST_BM   = '0;
    case (state_q)
      ST_RUN: begin
        BUSY        = 1'b1;
        A_BIST_EN   = 1'b1;
        A_BIST_MEN  = 1'b1;
        A_BIST_ADDR = addr_q;
        if (op_is_read) begin
          A_BIST_REN = 1'b1;
        end else begin
          A_BIST_WEN = 1'b1;
          A_BIST_BM  = '1;
          A_BIST_DIN = write_one ? ~P_BACKGROUND : P_BACKGROUND;
        end
      end
      ST_DRAIN: begin
        BUSY      = 1'b1;
        A_BIST_EN = 1'b1;
      end
      ST_DONE: begin
        DONE = 1'b1;
      end
      default: begin
        BUSY = 1'b0;
      end
    endcase
  end

  // State, element, address and phase registers
  always_ff @(posedge A_BIST_CLK) begin
    if (A_BIST_RST) begin
      state_q <= ST_IDLE;
      elem_q  <= 3'd0;
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
    end
  end

  // Remember what each read should return, so it can be checked when A_DOUT arrives
  always_ff @(posedge A_BIST_CLK) begin
    if (A_BIST_RST) begin
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
      cmp_addr  <= '0;
      cmp_elem  <= 3'd0;
    end else begin
      cmp_valid <= (state_q == ST_RUN) && op_is_read;
      cmp_exp   <= read_expects_one ? ~P_BACKGROUND : P_BACKGROUND;
      cmp_addr  <= addr_q;
      cmp_elem  <= elem_q;
    end
  end

  assign syndrome   = A_DOUT ^ cmp_exp;
  assign miscompare = cmp_valid && (|syndrome);

  // Sticky failure flag, first-failure capture and saturating miscompare count
  always_ff @(posedge A_BIST_CLK) begin
    if (A_BIST_RST || start_run) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      fail_syn_q  <= '0;
      fail_cnt_q  <= 8'd0;
    end else if (miscompare) begin
      if (fail_cnt_q != 8'hFF) begin
        fail_cnt_q <= fail_cnt_q + 8'd1;
      end
      if (!fail_q) begin
        fail_q      <= 1'b1;
        fail_addr_q <= cmp_addr;
        fail_elem_q <= cmp_elem;
        fail_syn_q  <= syndrome;
      end
    end
  end

  assign FAIL      = fail_q;
  assign FAIL_ADDR = fail_addr_q;
  assign FAIL_ELEM = fail_elem_q;
  assign FAIL_SYN  = fail_syn_q;
  assign FAIL_CNT  = fail_cnt_q;

endmodule
